// File: rtl/multi_mode_bounce_counter_pkg.sv
// Shared definitions for the multi-mode bounce counter: mode encoding and direction values.
package mmbc_pkg;

  typedef enum logic [1:0] {
    MODE_PINGPONG  = 2'd0,
    MODE_WRAP_UP   = 2'd1,
    MODE_WRAP_DOWN = 2'd2,
    MODE_ONESHOT   = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/multi_mode_bounce_counter_if.sv
// Control/status bundle of the multi-mode bounce counter.
// The evt status line exists only when MMBC_EVT_EN is defined.
interface multi_mode_bounce_counter_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
);
  logic              enable;
  logic              flip;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [1:0]        mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  max;
  logic [WIDTH-1:0]  min;
  logic [WIDTH-1:0]  out;
  logic              direction;
  logic              done;
`ifdef MMBC_EVT_EN
  logic              evt;
`endif

  modport master (
    output enable, flip, load, load_val, mode, step, max, min,
`ifdef MMBC_EVT_EN
    input  evt,
`endif
    input  out, direction, done
  );

  modport slave (
    input  enable, flip, load, load_val, mode, step, max, min,
`ifdef MMBC_EVT_EN
    output evt,
`endif
    output out, direction, done
  );
endinterface

// File: rtl/multi_mode_bounce_counter_step_unit.sv
// Combinational clamped step: adds or subtracts the effective step in WIDTH+1 bits and
// clamps to the active bound; hit_o flags that the result sits on that bound.
module mmbc_step_unit #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic [WIDTH-1:0]  val_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_i,
  input  logic [WIDTH-1:0]  min_i,
  input  logic [WIDTH-1:0]  max_i,
  output logic [WIDTH-1:0]  nxt_o,
  output logic              hit_o
);
  logic [WIDTH-1:0] s_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   lim_w;

  always_comb begin
    s_w   = (step_i == '0) ? WIDTH'(1) : WIDTH'(step_i);
    sum_w = {1'b0, val_i} + {1'b0, s_w};
    lim_w = {1'b0, min_i} + {1'b0, s_w};
    nxt_o = val_i;
    if (up_i) begin
      nxt_o = (sum_w > {1'b0, max_i}) ? max_i : sum_w[WIDTH-1:0];
    end else begin
      // subtraction only taken when it cannot underflow past min
      nxt_o = ({1'b0, val_i} < lim_w) ? min_i : (val_i - s_w);
    end
    hit_o = up_i ? (nxt_o == max_i) : (nxt_o == min_i);
  end
endmodule

// File: rtl/multi_mode_bounce_counter.sv
// Multi-mode bounce counter: ping-pong, wrap-up, wrap-down and one-shot counting between
// runtime bounds. Define MMBC_EVT_EN to add the one-cycle reversal/wrap pulse evt.
module multi_mode_bounce_counter
  import mmbc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input logic clk,
  input logic rst_n,
  multi_mode_bounce_counter_if.slave bus
);
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  mode_e            mode_w;
  logic             legal_w;
  logic             advance_w;
  logic             at_bound_w;
  logic             new_dir_w;
  logic [WIDTH-1:0] nxt_w;
  logic             hit_w;

  assign mode_w    = mode_e'(bus.mode);
  assign legal_w   = (bus.min < bus.max) && (out_q >= bus.min) && (out_q <= bus.max);
  assign advance_w = !bus.load && legal_w && bus.enable;

  // In ping-pong a flip and a bound reversal cancel each other, so the direction toggles on their XOR.
  always_comb begin
    at_bound_w = 1'b0;
    new_dir_w  = dir_q;
    case (mode_w)
      MODE_PINGPONG: begin
        at_bound_w = dir_q ? (out_q == bus.max) : (out_q == bus.min);
        new_dir_w  = (at_bound_w ^ bus.flip) ? ~dir_q : dir_q;
      end
      MODE_WRAP_UP:   new_dir_w = DIR_UP;
      MODE_WRAP_DOWN: new_dir_w = DIR_DOWN;
      MODE_ONESHOT:   new_dir_w = DIR_UP;
    endcase
  end

  mmbc_step_unit #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .val_i  (out_q),
    .step_i (bus.step),
    .up_i   (new_dir_w),
    .min_i  (bus.min),
    .max_i  (bus.max),
    .nxt_o  (nxt_w),
    .hit_o  (hit_w)
  );

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    done_d = done_q;
    if (bus.load) begin
      out_d  = bus.load_val;
      dir_d  = DIR_UP;
      done_d = 1'b0;
    end else if (advance_w) begin
      case (mode_w)
        MODE_PINGPONG: begin
          out_d = nxt_w;
          dir_d = new_dir_w;
        end
        MODE_WRAP_UP: begin
          dir_d = DIR_UP;
          out_d = (out_q == bus.max) ? bus.min : nxt_w;
        end
        MODE_WRAP_DOWN: begin
          dir_d = DIR_DOWN;
          out_d = (out_q == bus.min) ? bus.max : nxt_w;
        end
        MODE_ONESHOT: begin
          // frozen once done until reset or load
          if (!done_q) begin
            out_d  = nxt_w;
            dir_d  = DIR_UP;
            done_d = hit_w;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= bus.min;
      dir_q  <= DIR_UP;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.direction = dir_q;
  assign bus.done      = done_q;

`ifdef MMBC_EVT_EN
  logic evt_q, evt_d;

  always_comb begin
    evt_d = 1'b0;
    if (advance_w) begin
      case (mode_w)
        MODE_PINGPONG:  evt_d = at_bound_w && !bus.flip;
        MODE_WRAP_UP:   evt_d = (out_q == bus.max);
        MODE_WRAP_DOWN: evt_d = (out_q == bus.min);
        MODE_ONESHOT:   evt_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign bus.evt = evt_q;
`endif
endmodule

// File: tb/tb_multi_mode_bounce_counter.sv
// Self-checking bench for multi_mode_bounce_counter: directed test-plan sequences with literal
// expectations, then randomized stimulus checked every cycle against a behavioural model.
module tb_multi_mode_bounce_counter;
  localparam int WIDTH  = 4;
  localparam int STEP_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_mode_bounce_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus();

  multi_mode_bounce_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // behavioural model state
  int m_out = 0;
  int m_dir = 1;
  int m_done = 0;
  int m_evt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int up_c(input int x, input int s, input int hi);
    return (x + s > hi) ? hi : x + s;
  endfunction

  function automatic int dn_c(input int x, input int s, input int lo);
    return (x - s < lo) ? lo : x - s;
  endfunction

  task automatic model_next();
    int s, mn, mx, nd, old;
    bit rev;
    mn  = int'(bus.min);
    mx  = int'(bus.max);
    s   = (bus.step == 0) ? 1 : int'(bus.step);
    old = m_out;
    m_evt = 0;
    if (!rst_n) begin
      m_out = mn; m_dir = 1; m_done = 0;
    end else if (bus.load) begin
      m_out = int'(bus.load_val); m_dir = 1; m_done = 0;
    end else if (bus.enable && mn < mx && old >= mn && old <= mx) begin
      case (int'(bus.mode))
        0: begin
          rev = (m_dir == 1 && old == mx) || (m_dir == 0 && old == mn);
          if (rev && bus.flip) nd = m_dir;
          else if (rev || bus.flip) nd = 1 - m_dir;
          else nd = m_dir;
          m_out = (nd == 1) ? up_c(old, s, mx) : dn_c(old, s, mn);
          m_dir = nd;
          m_evt = (rev && !bus.flip) ? 1 : 0;
        end
        1: begin
          m_dir = 1;
          m_out = (old == mx) ? mn : up_c(old, s, mx);
          m_evt = (old == mx) ? 1 : 0;
        end
        2: begin
          m_dir = 0;
          m_out = (old == mn) ? mx : dn_c(old, s, mn);
          m_evt = (old == mn) ? 1 : 0;
        end
        default: begin
          if (m_done == 0) begin
            m_out = up_c(old, s, mx);
            m_dir = 1;
            if (m_out == mx) m_done = 1;
          end
        end
      endcase
    end
  endtask

  // one clock: advance the model with the inputs present at the edge, then compare
  task automatic cycle();
    model_next();
    @(posedge clk);
    #1;
    chk("model_out", 32'(bus.out), 32'(m_out));
    chk("model_dir", 32'(bus.direction), 32'(m_dir));
    chk("model_done", 32'(bus.done), 32'(m_done));
`ifdef MMBC_EVT_EN
    chk("model_evt", 32'(bus.evt), 32'(m_evt));
`endif
  endtask

  task automatic setin(input bit en, input bit fl, input bit ld, input int lv,
                       input int md, input int st, input int mn, input int mx);
    bus.enable   = en;
    bus.flip     = fl;
    bus.load     = ld;
    bus.load_val = WIDTH'(lv);
    bus.mode     = 2'(md);
    bus.step     = STEP_W'(st);
    bus.min      = WIDTH'(mn);
    bus.max      = WIDTH'(mx);
  endtask

  int pp_out[7] = '{3, 4, 5, 4, 3, 2, 3};
  int pp_dir[7] = '{1, 1, 1, 0, 0, 0, 1};
  int pp_evt[7] = '{0, 0, 0, 1, 0, 0, 1};
  int wu_out[6] = '{3, 6, 9, 12, 15, 0};
  int os_out[5] = '{3, 5, 6, 6, 6};
  int os_don[5] = '{0, 0, 1, 1, 1};

  initial begin
    // reset
    rst_n = 1'b0;
    setin(0, 0, 0, 0, 0, 1, 2, 5);
    cycle();
    chk("rst_out", 32'(bus.out), 2);
    chk("rst_dir", 32'(bus.direction), 1);
    chk("rst_done", 32'(bus.done), 0);
`ifdef MMBC_EVT_EN
    chk("rst_evt", 32'(bus.evt), 0);
`endif
    rst_n = 1'b1;

    // ping-pong 2..5
    setin(1, 0, 0, 0, 0, 1, 2, 5);
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("pp_out", 32'(bus.out), 32'(pp_out[i]));
      chk("pp_dir", 32'(bus.direction), 32'(pp_dir[i]));
`ifdef MMBC_EVT_EN
      chk("pp_evt", 32'(bus.evt), 32'(pp_evt[i]));
`endif
    end

    // flip at out=3 going up
    bus.flip = 1'b1;
    cycle();
    chk("flip_out", 32'(bus.out), 2);
    chk("flip_dir", 32'(bus.direction), 0);
`ifdef MMBC_EVT_EN
    chk("flip_evt", 32'(bus.evt), 0);
`endif
    bus.flip = 1'b0;

    // wrap-up 0..15 step 3
    setin(0, 0, 1, 0, 1, 3, 0, 15);
    cycle();
    chk("wu_load", 32'(bus.out), 0);
    setin(1, 0, 0, 0, 1, 3, 0, 15);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("wu_out", 32'(bus.out), 32'(wu_out[i]));
`ifdef MMBC_EVT_EN
      chk("wu_evt", 32'(bus.evt), (i == 5) ? 1 : 0);
`endif
    end

    // one-shot 1..6 step 2
    setin(0, 0, 1, 1, 3, 2, 1, 6);
    cycle();
    setin(1, 0, 0, 0, 3, 2, 1, 6);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("os_out", 32'(bus.out), 32'(os_out[i]));
      chk("os_done", 32'(bus.done), 32'(os_don[i]));
    end
    setin(1, 0, 1, 4, 3, 2, 1, 6);
    cycle();
    chk("os_reload_out", 32'(bus.out), 4);
    chk("os_reload_done", 32'(bus.done), 0);

    // illegal range: min == max
    setin(1, 0, 0, 0, 0, 1, 7, 7);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("ill_eq_out", 32'(bus.out), 4);
      chk("ill_eq_dir", 32'(bus.direction), 1);
    end
    // load still works, then out above max holds
    setin(1, 0, 1, 9, 0, 1, 0, 8);
    cycle();
    chk("ill_load", 32'(bus.out), 9);
    setin(1, 0, 0, 0, 0, 1, 0, 8);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("ill_hi_out", 32'(bus.out), 9);
      chk("ill_hi_dir", 32'(bus.direction), 1);
    end

    // reset while counting down
    setin(0, 0, 1, 5, 2, 1, 1, 8);
    cycle();
    setin(1, 0, 0, 0, 2, 1, 1, 8);
    cycle();
    chk("dn_out", 32'(bus.out), 4);
    chk("dn_dir", 32'(bus.direction), 0);
    rst_n = 1'b0;
    cycle();
    chk("midrst_out", 32'(bus.out), 1);
    chk("midrst_dir", 32'(bus.direction), 1);
    chk("midrst_done", 32'(bus.done), 0);
    rst_n = 1'b1;

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        bus.mode = 2'($urandom_range(0, 3));
        bus.min  = WIDTH'($urandom_range(0, 15));
        if ($urandom_range(0, 4) != 0 && bus.min < 4'd15)
          bus.max = WIDTH'($urandom_range(int'(bus.min) + 1, 15));
        else
          bus.max = WIDTH'($urandom_range(0, 15));
      end
      rst_n        = ($urandom_range(0, 99) != 0);
      bus.load     = ($urandom_range(0, 24) == 0);
      bus.load_val = WIDTH'($urandom_range(0, 15));
      bus.enable   = ($urandom_range(0, 3) != 0);
      bus.flip     = ($urandom_range(0, 7) == 0);
      bus.step     = STEP_W'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
